// File: rtl/cs_block_scheduler_if.sv
// Handshake and status bundle between the block scheduler and its neighbours
// (measurement buffer, averaging datapath, SAD comparator).
interface cs_block_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 8
);

    // Control and configuration
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] frame_rows;
    logic [ADDR_WIDTH-1:0] frame_cols;

    // Measurement handshake
    logic                  meas_valid;
    logic                  meas_ready;

    // SAD comparator handshake
    logic                  sad_done;
    logic                  sad_start;

    // Averaging datapath controls
    logic [ADDR_WIDTH-1:0] rows;
    logic [ADDR_WIDTH-1:0] columns;
    logic                  data_available_flag;
    logic                  sad_busy_flag;

    // Status
    logic                  block_done;
    logic                  frame_done;
    logic                  busy;
    logic                  cfg_err;
    logic                  sad_timeout;

    // Driver side: whoever sequences frames and feeds measurements
    modport master (
        output start,
        output abort,
        output frame_rows,
        output frame_cols,
        output meas_valid,
        output sad_done,
        input  meas_ready,
        input  sad_start,
        input  rows,
        input  columns,
        input  data_available_flag,
        input  sad_busy_flag,
        input  block_done,
        input  frame_done,
        input  busy,
        input  cfg_err,
        input  sad_timeout
    );

    // Scheduler side
    modport slave (
        input  start,
        input  abort,
        input  frame_rows,
        input  frame_cols,
        input  meas_valid,
        input  sad_done,
        output meas_ready,
        output sad_start,
        output rows,
        output columns,
        output data_available_flag,
        output sad_busy_flag,
        output block_done,
        output frame_done,
        output busy,
        output cfg_err,
        output sad_timeout
    );

endinterface

// File: rtl/cs_block_scheduler.sv
// Raster-order block sequencer for the compressive-sensing intra-prediction
// averaging stage. Every output is a flop so nothing combinational reaches the
// datapath or the SAD unit from the inputs.
module cs_block_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned MAX_COLS    = 80,
    parameter int unsigned SAD_TIMEOUT = 255
) (
    input logic                    clk,
    input logic                    rst,
    cs_block_scheduler_if.slave    bus
);

    // Wide enough to hold SAD_TIMEOUT without wrapping
    localparam int unsigned CNT_W = $clog2(SAD_TIMEOUT + 2);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SAD_TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MEAS,
        ST_PREDICT,
        ST_SAD,
        ST_ADVANCE
    } state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] rows_q;
    logic [ADDR_WIDTH-1:0] cols_q;
    logic [ADDR_WIDTH-1:0] rows_lim_q;
    logic [ADDR_WIDTH-1:0] cols_lim_q;
    logic [CNT_W-1:0]      wait_cnt;

    logic meas_ready_q;
    logic sad_busy_q;
    logic data_avail_q;
    logic busy_q;
    logic sad_start_q;
    logic block_done_q;
    logic frame_done_q;
    logic cfg_err_q;
    logic sad_timeout_q;

    logic cfg_ok;
    logic last_col;
    logic last_blk;
    logic sad_done_ok;

    // Configuration check and end-of-row / end-of-frame detection
    always_comb begin
        cfg_ok = (bus.frame_rows != '0) && (bus.frame_cols != '0) &&
                 (32'(bus.frame_cols) <= MAX_COLS);
        last_col = (cols_q == cols_lim_q - IDX_ONE);
        last_blk = last_col && (rows_q == rows_lim_q - IDX_ONE);
        // sad_done is not trusted in the cycle that launches the SAD unit
        sad_done_ok = bus.sad_done && !sad_start_q;
    end

    // Sequencer: state, indices, wait counter and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            rows_lim_q    <= '0;
            cols_lim_q    <= '0;
            wait_cnt      <= '0;
            meas_ready_q  <= 1'b0;
            sad_busy_q    <= 1'b1;
            data_avail_q  <= 1'b0;
            busy_q        <= 1'b0;
            sad_start_q   <= 1'b0;
            block_done_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            sad_timeout_q <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle
            sad_start_q  <= 1'b0;
            block_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;

            if (bus.abort) begin
                // Indices are kept so software can see where the frame stopped
                state        <= ST_IDLE;
                meas_ready_q <= 1'b0;
                sad_busy_q   <= 1'b1;
                data_avail_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (cfg_ok) begin
                                rows_lim_q    <= bus.frame_rows;
                                cols_lim_q    <= bus.frame_cols;
                                rows_q        <= '0;
                                cols_q        <= '0;
                                sad_timeout_q <= 1'b0;
                                state         <= ST_WAIT_MEAS;
                                meas_ready_q  <= 1'b1;
                                busy_q        <= 1'b1;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end

                    ST_WAIT_MEAS: begin
                        if (bus.meas_valid) begin
                            state        <= ST_PREDICT;
                            meas_ready_q <= 1'b0;
                            sad_busy_q   <= 1'b0;
                            data_avail_q <= 1'b1;
                        end
                    end

                    ST_PREDICT: begin
                        // One cycle of recompute + line-memory write, then freeze
                        state        <= ST_SAD;
                        sad_busy_q   <= 1'b1;
                        data_avail_q <= 1'b0;
                        sad_start_q  <= 1'b1;
                        wait_cnt     <= '0;
                    end

                    ST_SAD: begin
                        if (sad_done_ok) begin
                            state        <= ST_ADVANCE;
                            block_done_q <= 1'b1;
                        end else if (wait_cnt == CNT_MAX) begin
                            state         <= ST_ADVANCE;
                            block_done_q  <= 1'b1;
                            sad_timeout_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_ONE;
                        end
                    end

                    ST_ADVANCE: begin
                        if (last_blk) begin
                            state        <= ST_IDLE;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            if (last_col) begin
                                cols_q <= '0;
                                rows_q <= rows_q + IDX_ONE;
                            end else begin
                                cols_q <= cols_q + IDX_ONE;
                            end
                            state        <= ST_WAIT_MEAS;
                            meas_ready_q <= 1'b1;
                        end
                    end

                    default: begin
                        state        <= ST_IDLE;
                        meas_ready_q <= 1'b0;
                        sad_busy_q   <= 1'b1;
                        data_avail_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Drive the bundle straight from flops
    always_comb begin
        bus.meas_ready          = meas_ready_q;
        bus.sad_start           = sad_start_q;
        bus.rows                = rows_q;
        bus.columns             = cols_q;
        bus.data_available_flag = data_avail_q;
        bus.sad_busy_flag       = sad_busy_q;
        bus.block_done          = block_done_q;
        bus.frame_done          = frame_done_q;
        bus.busy                = busy_q;
        bus.cfg_err             = cfg_err_q;
        bus.sad_timeout         = sad_timeout_q;
    end

endmodule

// File: tb/tb_cs_block_scheduler.sv
// Directed bench for cs_block_scheduler: configuration table, a full 2x3
// frame, stalled measurements, reset and abort mid-frame, SAD timeout.
module tb_cs_block_scheduler;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cs_block_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    cs_block_scheduler #(
        .ADDR_WIDTH  (AW),
        .MAX_COLS    (80),
        .SAD_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string     name;
        logic [7:0] r;
        logic [7:0] c;
        logic      exp_err;
        logic      exp_busy;
    } cfg_vec_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] c;
    } idx_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    cfg_vec_t cfg_tab[6];
    idx_t     exp_idx[6];

    initial begin
        int  nblk;
        int  nfd;
        int  last_bd;
        int  cyc;
        int  n;
        bit  prev_ss;
        bit  seen;
        bit  stray;

        cfg_tab[0] = '{"cfg_ok_2x3",    8'd2, 8'd3,  1'b0, 1'b1};
        cfg_tab[1] = '{"cfg_rows0",     8'd0, 8'd3,  1'b1, 1'b0};
        cfg_tab[2] = '{"cfg_cols81",    8'd2, 8'd81, 1'b1, 1'b0};
        cfg_tab[3] = '{"cfg_cols80",    8'd1, 8'd80, 1'b0, 1'b1};
        cfg_tab[4] = '{"cfg_cols0",     8'd2, 8'd0,  1'b1, 1'b0};
        cfg_tab[5] = '{"cfg_cols255",   8'd1, 8'd255, 1'b1, 1'b0};

        exp_idx[0] = '{8'd0, 8'd0};
        exp_idx[1] = '{8'd0, 8'd1};
        exp_idx[2] = '{8'd0, 8'd2};
        exp_idx[3] = '{8'd1, 8'd0};
        exp_idx[4] = '{8'd1, 8'd1};
        exp_idx[5] = '{8'd1, 8'd2};

        bus.start = 0; bus.abort = 0; bus.frame_rows = 0; bus.frame_cols = 0;
        bus.meas_valid = 0; bus.sad_done = 0;

        // ---- reset values ----
        rst = 1'b1;
        #2;
        chk("rst_rows", int'(bus.rows), 0);
        chk("rst_cols", int'(bus.columns), 0);
        chk("rst_sad_busy", int'(bus.sad_busy_flag), 1);
        chk("rst_dav", int'(bus.data_available_flag), 0);
        chk("rst_meas_ready", int'(bus.meas_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pulses", int'({bus.sad_start, bus.block_done, bus.frame_done, bus.cfg_err}), 0);
        chk("rst_sad_timeout", int'(bus.sad_timeout), 0);
        tick();
        rst = 1'b0;
        tick();

        // ---- configuration table ----
        for (int i = 0; i < 6; i++) begin
            bus.frame_rows = cfg_tab[i].r;
            bus.frame_cols = cfg_tab[i].c;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk({cfg_tab[i].name, "_err"}, int'(bus.cfg_err), int'(cfg_tab[i].exp_err));
            chk({cfg_tab[i].name, "_busy"}, int'(bus.busy), int'(cfg_tab[i].exp_busy));
            chk({cfg_tab[i].name, "_ready"}, int'(bus.meas_ready), int'(cfg_tab[i].exp_busy));
            tick();
            chk({cfg_tab[i].name, "_err_pulse"}, int'(bus.cfg_err), 0);
            if (bus.busy) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
            end
        end

        // ---- full 2x3 frame, measurements always available ----
        bus.frame_rows = 8'd2;
        bus.frame_cols = 8'd3;
        bus.meas_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("frm_start_rows", int'(bus.rows), 0);
        chk("frm_start_cols", int'(bus.columns), 0);
        nblk = 0; nfd = 0; last_bd = -1; cyc = 0; prev_ss = 0;
        for (int i = 0; i < 80 && nfd == 0; i++) begin
            tick();
            cyc++;
            // sad_done exactly one cycle after sad_start
            bus.sad_done = prev_ss;
            prev_ss = bus.sad_start;
            if (bus.block_done) begin
                if (nblk < 6) begin
                    chk($sformatf("frm_blk%0d_row", nblk), int'(bus.rows), int'(exp_idx[nblk].r));
                    chk($sformatf("frm_blk%0d_col", nblk), int'(bus.columns), int'(exp_idx[nblk].c));
                end
                if (last_bd >= 0) chk($sformatf("frm_gap%0d", nblk), cyc - last_bd, 5);
                last_bd = cyc;
                nblk++;
            end
            if (bus.frame_done) begin
                nfd++;
                chk("frm_done_after_last", cyc - last_bd, 1);
                chk("frm_done_busy", int'(bus.busy), 0);
            end
        end
        bus.sad_done = 1'b0;
        chk("frm_nblocks", nblk, 6);
        chk("frm_nframe_done", nfd, 1);
        tick();
        chk("frm_done_pulse", int'(bus.frame_done), 0);
        chk("frm_end_idx", int'({bus.rows, bus.columns}), int'({8'd1, 8'd2}));
        chk("frm_end_idle_ready", int'(bus.meas_ready), 0);

        // ---- measurements withheld, then reset in PREDICT of block (0,1) ----
        bus.meas_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sad_busy_flag !== 1'b1 || bus.data_available_flag !== 1'b0 ||
                bus.rows !== 8'd0 || bus.columns !== 8'd0 || bus.meas_ready !== 1'b1)
                stray = 1;
        end
        chk("stall_stable", int'(stray), 0);
        bus.meas_valid = 1'b1;
        tick();
        chk("stall_pred_sad_busy", int'(bus.sad_busy_flag), 0);
        chk("stall_pred_dav", int'(bus.data_available_flag), 1);
        chk("stall_pred_ready", int'(bus.meas_ready), 0);
        bus.sad_done = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.data_available_flag && bus.columns == 8'd1) seen = 1;
        end
        chk("rstmid_reached", int'(seen), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_sad_busy", int'(bus.sad_busy_flag), 1);
        chk("rstmid_dav", int'(bus.data_available_flag), 0);
        chk("rstmid_idx", int'({bus.rows, bus.columns}), 0);
        chk("rstmid_busy", int'(bus.busy), 0);
        tick();
        rst = 1'b0;
        tick();

        // ---- abort in SAD at block (1,1) ----
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.sad_start && bus.rows == 8'd1 && bus.columns == 8'd1) seen = 1;
        end
        chk("abort_reached", int'(seen), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.sad_done = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_rows", int'(bus.rows), 1);
        chk("abort_cols", int'(bus.columns), 1);
        chk("abort_no_block_done", int'(bus.block_done), 0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.frame_done || bus.block_done || bus.busy) stray = 1;
        end
        chk("abort_quiet", int'(stray), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_idx", int'({bus.rows, bus.columns}), 0);
        chk("restart_busy", int'(bus.busy), 1);
        // abort and meas_valid together: measurement not consumed
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_vs_meas_dav", int'(bus.data_available_flag), 0);
        chk("abort_vs_meas_busy", int'(bus.busy), 0);
        chk("abort_vs_meas_sad_busy", int'(bus.sad_busy_flag), 1);

        // ---- SAD timeout, sad_done never arrives ----
        bus.frame_rows = 8'd1;
        bus.frame_cols = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.sad_start) seen = 1;
        end
        chk("to_sad_start", int'(seen), 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (bus.block_done) seen = 1;
        end
        chk("to_adv_delay", n, 5);
        chk("to_flag", int'(bus.sad_timeout), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("to_sticky", int'(bus.sad_timeout), 1);
        chk("to_idle", int'(bus.busy), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("to_clear_on_start", int'(bus.sad_timeout), 0);

        // ---- sad_done on the very cycle the timeout expires ----
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.sad_start) seen = 1;
        end
        chk("edge_sad_start", int'(seen), 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            bus.sad_done = (n == 4);
            if (bus.block_done) seen = 1;
        end
        bus.sad_done = 1'b0;
        chk("edge_adv_delay", n, 5);
        chk("edge_no_timeout", int'(bus.sad_timeout), 0);
        tick();
        chk("edge_frame_done", int'(bus.frame_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
